// File: rtl/fp_class_pkg.sv
// Shared definitions for the FP class statistics block: bin order, readout indices
// and the class groups that drive the sticky flags.
package fp_class_pkg;

    localparam int NCLS      = 10;
    localparam int IDX_ERR   = 10;
    localparam int IDX_TOTAL = 11;
    localparam int NCNT      = 12;

    typedef enum logic [3:0] {
        CLS_SNAN         = 4'd0,
        CLS_QNAN         = 4'd1,
        CLS_NEG_INF      = 4'd2,
        CLS_NEG_NORMAL   = 4'd3,
        CLS_NEG_DENORMAL = 4'd4,
        CLS_NEG_ZERO     = 4'd5,
        CLS_POS_ZERO     = 4'd6,
        CLS_POS_DENORMAL = 4'd7,
        CLS_POS_NORMAL   = 4'd8,
        CLS_POS_INF      = 4'd9
    } fp_class_e;

    // Bit masks over the one-hot class vector, one per sticky flag
    localparam logic [NCLS-1:0] NAN_MASK = 10'b00_0000_0011;
    localparam logic [NCLS-1:0] INF_MASK = 10'b10_0000_0100;
    localparam logic [NCLS-1:0] DEN_MASK = 10'b00_1001_0000;

    function automatic logic is_onehot(input logic [NCLS-1:0] v);
        return (v != '0) && ((v & (v - {{(NCLS-1){1'b0}}, 1'b1})) == '0);
    endfunction

endpackage

// File: rtl/fp_class_stats_sat_counter.sv
// Saturating event counter: holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && (cnt != {W{1'b1}}))
            cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/fp_class_stats.sv
// Per-class event statistics behind fp_classify: two-stage count pipeline,
// sticky exception flags and a snapshot bank read out one word per request.
module fp_class_stats
    import fp_class_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NCLS-1:0]  in_class,
    input  logic             clr,
    input  logic             snap,
    input  logic             rd_req,
    input  logic [3:0]       rd_idx,
    output logic             rd_valid,
    output logic [CNT_W-1:0] rd_data,
    output logic             sticky_nan,
    output logic             sticky_inf,
    output logic             sticky_den,
    output logic             err_onehot
);

    localparam logic [3:0] RD_LAST = 4'(IDX_TOTAL);

    logic                         accept;
    logic                         s1_vld;
    logic [NCLS-1:0]              s1_class;
    logic                         s1_onehot;
    logic [NCNT-1:0]              inc;
    logic [NCNT-1:0][CNT_W-1:0]   live;
    logic [NCNT-1:0][CNT_W-1:0]   bank;

    // Only clr stalls the input; readout and snapshots never backpressure
    assign in_ready = rst_n && !clr;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld   <= 1'b0;
            s1_class <= '0;
        end else if (clr) begin
            s1_vld   <= 1'b0;
        end else begin
            s1_vld <= accept;
            if (accept)
                s1_class <= in_class;
        end
    end

    assign s1_onehot        = is_onehot(s1_class);
    assign inc[NCLS-1:0]    = (s1_vld && s1_onehot) ? s1_class : '0;
    assign inc[IDX_ERR]     = s1_vld && !s1_onehot;
    assign inc[IDX_TOTAL]   = s1_vld;

    for (genvar g = 0; g < NCNT; g++) begin : g_cnt
        sat_counter #(.W(CNT_W)) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (inc[g]),
            .clr   (clr),
            .cnt   (live[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_nan <= 1'b0;
            sticky_inf <= 1'b0;
            sticky_den <= 1'b0;
            err_onehot <= 1'b0;
        end else if (clr) begin
            sticky_nan <= 1'b0;
            sticky_inf <= 1'b0;
            sticky_den <= 1'b0;
            err_onehot <= 1'b0;
        end else begin
            if (|(inc[NCLS-1:0] & NAN_MASK)) sticky_nan <= 1'b1;
            if (|(inc[NCLS-1:0] & INF_MASK)) sticky_inf <= 1'b1;
            if (|(inc[NCLS-1:0] & DEN_MASK)) sticky_den <= 1'b1;
            if (inc[IDX_ERR])                err_onehot <= 1'b1;
        end
    end

    // Bank copies the registered counters, so a same-edge S2 update or clear is
    // excluded, and a same-edge read sees the previous bank contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank     <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            if (snap)
                bank <= live;
            rd_valid <= rd_req;
            if (rd_req)
                rd_data <= (rd_idx <= RD_LAST) ? bank[rd_idx] : '0;
        end
    end

endmodule
